// File: rtl/ex_sta_frame_tx_pkg.sv
// ex_sta_frame_tx_pkg
//   Shared constants and FSM encoding for the EX status frame transmitter.
//   Word layout: [SOF_BIT] start of frame, [EOF_BIT] end of frame, [15:0] payload.
`timescale 1ns/1ps
package ex_sta_frame_tx_pkg;

  localparam int         SOF_BIT    = 17;
  localparam int         EOF_BIT    = 16;
  localparam logic [7:0] HDR_TAG    = 8'hA5;
  localparam int         FRAME_LEN  = 34;
  localparam logic [15:0] MIN_PERIOD = 16'd36;
  localparam int         WORD_CNT   = 32;
  localparam int         ADDR_W     = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_HDR  = 3'd2,
    ST_PAY  = 3'd3,
    ST_CSUM = 3'd4
  } tx_state_t;

  // Header-to-header spacing actually used; short periods cannot fit a frame.
  function automatic logic [15:0] eff_period(input logic [15:0] period);
    return (period < MIN_PERIOD) ? MIN_PERIOD : period;
  endfunction

endpackage

// File: rtl/ex_sta_regbank.sv
// ex_sta_regbank
//   Live + shadow status register banks (32 x 16).
//   clk_150m, rst_150m        : clock, async active-low reset (clears both banks)
//   wr_en, wr_addr, wr_data   : live bank write port, committed on the next edge
//   snap                      : copy live -> shadow on this edge
//   rd_addr, rd_data          : shadow read port
`timescale 1ns/1ps
module ex_sta_regbank
  import ex_sta_frame_tx_pkg::*;
(
  input  logic              clk_150m,
  input  logic              rst_150m,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic              snap,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [15:0]       rd_data
);

  logic [15:0] live_q   [WORD_CNT];
  logic [15:0] shadow_q [WORD_CNT];

  always_ff @(posedge clk_150m or negedge rst_150m) begin
    if (!rst_150m) begin
      for (int i = 0; i < WORD_CNT; i++) live_q[i] <= 16'h0;
    end else if (wr_en) begin
      live_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk_150m or negedge rst_150m) begin
    if (!rst_150m) begin
      for (int i = 0; i < WORD_CNT; i++) shadow_q[i] <= 16'h0;
    end else if (snap) begin
      for (int i = 0; i < WORD_CNT; i++) shadow_q[i] <= live_q[i];
    end
  end

  // The first payload word is registered on the same edge that loads the
  // shadow, so during the snapshot cycle the read bypasses to the live value
  // the shadow is about to take (a write in this cycle is not yet visible).
  assign rd_data = snap ? live_q[rd_addr] : shadow_q[rd_addr];

endmodule

// File: rtl/ex_sta_frame_tx.sv
// ex_sta_frame_tx
//   Periodic EX status frame transmitter: header, 32 status words, checksum.
//   clk_150m, rst_150m             : clock, async active-low reset
//   tx_en                          : enable periodic transmission
//   frame_period[15:0]             : header-to-header spacing (min 36)
//   box_id[3:0]                    : box number placed in header
//   sta_wr_en/addr[4:0]/data[15:0] : status register write port
//   sta_dval, sta_data[17:0]       : frame word stream (SOF, EOF, payload)
//   tx_busy                        : frame on the wire
//   frame_cnt[15:0]                : completed frames (wrapping)
//
//   state | meaning
//   IDLE  | transmission off, waiting for tx_en (armed after one high sample)
//   WAIT  | between frames, period counter running
//   HDR   | header word on the wire, live bank snapshot taken
//   PAY   | payload words 1..32 from shadow bank
//   CSUM  | checksum word with EOF
`timescale 1ns/1ps
module ex_sta_frame_tx
  import ex_sta_frame_tx_pkg::*;
(
  input  logic        clk_150m,
  input  logic        rst_150m,
  input  logic        tx_en,
  input  logic [15:0] frame_period,
  input  logic [3:0]  box_id,
  input  logic        sta_wr_en,
  input  logic [4:0]  sta_wr_addr,
  input  logic [15:0] sta_wr_data,
  output logic        sta_dval,
  output logic [17:0] sta_data,
  output logic        tx_busy,
  output logic [15:0] frame_cnt
);

  tx_state_t   state_q, state_d;
  logic        arm_q;
  logic [4:0]  pay_idx_q, pay_idx_d;
  logic [15:0] per_cnt_q;
  logic [15:0] sum_q, sum_d;
  logic [15:0] rd_data;
  logic        snap;
  logic        dval_d;
  logic [17:0] word_d;

  assign snap = (state_q == ST_HDR);

  ex_sta_regbank u_regbank (
    .clk_150m (clk_150m),
    .rst_150m (rst_150m),
    .wr_en    (sta_wr_en),
    .wr_addr  (sta_wr_addr),
    .wr_data  (sta_wr_data),
    .snap     (snap),
    .rd_addr  (pay_idx_d),
    .rd_data  (rd_data)
  );

  always_comb begin
    state_d   = state_q;
    pay_idx_d = pay_idx_q;
    case (state_q)
      ST_IDLE: if (arm_q && tx_en) state_d = ST_HDR;
      ST_WAIT: if (per_cnt_q >= eff_period(frame_period) - 16'd1) state_d = ST_HDR;
      ST_HDR: begin
        state_d   = ST_PAY;
        pay_idx_d = 5'd0;
      end
      ST_PAY: begin
        if (pay_idx_q == 5'(WORD_CNT - 1)) state_d = ST_CSUM;
        else pay_idx_d = pay_idx_q + 5'd1;
      end
      ST_CSUM: state_d = tx_en ? ST_WAIT : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed for the upcoming state so the registered word lines
  // up with the state register.
  always_comb begin
    dval_d = 1'b0;
    word_d = 18'h0;
    sum_d  = sum_q;
    case (state_d)
      ST_HDR: begin
        dval_d          = 1'b1;
        word_d[15:0]    = {HDR_TAG, box_id, 4'h0};
        word_d[SOF_BIT] = 1'b1;
        sum_d           = {HDR_TAG, box_id, 4'h0};
      end
      ST_PAY: begin
        dval_d       = 1'b1;
        word_d[15:0] = rd_data;
        sum_d        = sum_q + rd_data;
      end
      ST_CSUM: begin
        dval_d          = 1'b1;
        word_d[15:0]    = sum_q;
        word_d[EOF_BIT] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_150m or negedge rst_150m) begin
    if (!rst_150m) begin
      state_q   <= ST_IDLE;
      arm_q     <= 1'b0;
      pay_idx_q <= 5'd0;
      per_cnt_q <= 16'd0;
      sum_q     <= 16'd0;
      sta_dval  <= 1'b0;
      sta_data  <= 18'h0;
      tx_busy   <= 1'b0;
      frame_cnt <= 16'd0;
    end else begin
      state_q   <= state_d;
      arm_q     <= (state_q == ST_IDLE) && tx_en;
      pay_idx_q <= pay_idx_d;
      sum_q     <= sum_d;
      // Zero in the header cycle so the WAIT compare measures from the header.
      if (state_d == ST_HDR || state_q == ST_IDLE) per_cnt_q <= 16'd0;
      else per_cnt_q <= per_cnt_q + 16'd1;
      sta_dval  <= dval_d;
      sta_data  <= word_d;
      tx_busy   <= dval_d;
      if (state_d == ST_CSUM) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ex_sta_frame_tx.sv
`timescale 1ns/1ps
module tb_ex_sta_frame_tx;

  logic        clk_150m = 1'b0;
  logic        rst_150m = 1'b1;
  logic        tx_en = 1'b0;
  logic [15:0] frame_period = 16'd100;
  logic [3:0]  box_id = 4'h3;
  logic        sta_wr_en = 1'b0;
  logic [4:0]  sta_wr_addr = 5'd0;
  logic [15:0] sta_wr_data = 16'h0;
  logic        sta_dval;
  logic [17:0] sta_data;
  logic        tx_busy;
  logic [15:0] frame_cnt;

  always #3 clk_150m = ~clk_150m;

  ex_sta_frame_tx dut (
    .clk_150m     (clk_150m),
    .rst_150m     (rst_150m),
    .tx_en        (tx_en),
    .frame_period (frame_period),
    .box_id       (box_id),
    .sta_wr_en    (sta_wr_en),
    .sta_wr_addr  (sta_wr_addr),
    .sta_wr_data  (sta_wr_data),
    .sta_dval     (sta_dval),
    .sta_data     (sta_data),
    .tx_busy      (tx_busy),
    .frame_cnt    (frame_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  longint cyc = 0;

  // Reference model: frame schedule plus live/snapshot bank contents.
  logic [15:0] live_m [32];
  logic [15:0] snap_m [32];
  logic [15:0] snap_sum;
  logic [3:0]  snap_box;
  bit          sched;
  longint      fs, nh;
  int          idle_cnt;
  logic [15:0] exp_fc;
  int          cur_pos;

  // Stimulus for the next cycle and one-shot hooks.
  bit          tx_nxt, wr_nxt, hook_wr, hook_drop;
  logic [4:0]  wa_nxt, hook_a;
  logic [15:0] wd_nxt, hook_d;

  // Observed stream records.
  int          obs_hdr_n, obs_eof_n, obs_pos;
  logic [17:0] obs_hdr_w [8];
  logic [17:0] obs_eof_w [8];
  logic [17:0] obs_w1    [8];
  longint      obs_hdr_cyc [8];

  typedef struct {
    logic [3:0]  box;
    logic [15:0] period;
    int          nwr;
    logic [4:0]  a0;
    logic [15:0] d0;
    logic [4:0]  a1;
    logic [15:0] d1;
    logic [17:0] exp_hdr;
    logic [17:0] exp_csum;
    int          exp_gap;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint eff(input logic [15:0] p);
    return (p < 16'd36) ? 64'd36 : longint'(p);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin live_m[i] = 16'h0; snap_m[i] = 16'h0; end
    sched = 0; fs = -1000; nh = 0; idle_cnt = 0; exp_fc = 16'h0; cur_pos = -1;
    obs_hdr_n = 0; obs_eof_n = 0; obs_pos = 0;
    hook_wr = 0; hook_drop = 0; tx_nxt = 0; wr_nxt = 0;
  endtask

  // Called at a falling edge: asserts reset, checks outputs cleared at once,
  // holds three cycles and releases with tx_en low.
  task automatic reset_now();
    rst_150m = 1'b0;
    tx_en = 1'b0;
    sta_wr_en = 1'b0;
    #1;
    chk("rst_dval", 32'(sta_dval), 32'd0);
    chk("rst_data", 32'(sta_data), 32'd0);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_fcnt", 32'(frame_cnt), 32'd0);
    model_clear();
    repeat (3) begin @(negedge clk_150m); cyc++; end
    rst_150m = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk_150m); cyc++;
    reset_now();
  endtask

  task automatic step();
    bit hdr_now, idle_mode;
    logic [17:0] ew;
    bit edv;
    longint p;
    @(negedge clk_150m);
    cyc++;
    idle_mode = !sched;
    hdr_now = sched ? (cyc == nh) : (idle_cnt >= 2);
    if (hdr_now) begin
      fs = cyc; sched = 1; nh = cyc + eff(frame_period);
      snap_box = box_id;
      snap_sum = {8'hA5, box_id, 4'h0};
      for (int i = 0; i < 32; i++) begin
        snap_m[i] = live_m[i];
        snap_sum = snap_sum + live_m[i];
      end
    end
    p = cyc - fs;
    cur_pos = (p >= 0 && p <= 33) ? int'(p) : -1;
    ew = 18'h0;
    if (cur_pos == 0) ew = {2'b10, 8'hA5, snap_box, 4'h0};
    else if (cur_pos >= 1 && cur_pos <= 32) ew = {2'b00, snap_m[cur_pos-1]};
    else if (cur_pos == 33) begin ew = {2'b01, snap_sum}; exp_fc = exp_fc + 16'd1; end
    edv = (cur_pos >= 0);
    chk("dval", 32'(sta_dval), 32'(edv));
    chk("data", 32'(sta_data), 32'(ew));
    chk("busy", 32'(tx_busy), 32'(edv));
    chk("frame_cnt", 32'(frame_cnt), 32'(exp_fc));

    if (sta_dval === 1'b1 && sta_data[17] === 1'b1) begin
      if (obs_hdr_n < 8) begin obs_hdr_w[obs_hdr_n] = sta_data; obs_hdr_cyc[obs_hdr_n] = cyc; end
      obs_hdr_n++;
      obs_pos = 0;
    end else if (sta_dval === 1'b1) begin
      obs_pos++;
    end
    if (sta_dval === 1'b1 && obs_pos == 1 && obs_hdr_n >= 1 && obs_hdr_n <= 8) obs_w1[obs_hdr_n-1] = sta_data;
    if (sta_dval === 1'b1 && sta_data[16] === 1'b1) begin
      if (obs_eof_n < 8) obs_eof_w[obs_eof_n] = sta_data;
      obs_eof_n++;
    end

    if (hook_drop && cur_pos == 10) begin tx_nxt = 0; hook_drop = 0; end
    tx_en = tx_nxt;
    if (hook_wr && cur_pos == 0) begin
      sta_wr_en = 1'b1; sta_wr_addr = hook_a; sta_wr_data = hook_d; hook_wr = 0;
    end else begin
      sta_wr_en = wr_nxt; sta_wr_addr = wa_nxt; sta_wr_data = wd_nxt;
    end

    if (sta_wr_en) live_m[sta_wr_addr] = sta_wr_data;
    if (cur_pos == 33 && !tx_en) sched = 0;
    if (idle_mode && !hdr_now) idle_cnt = tx_en ? idle_cnt + 1 : 0;
    else idle_cnt = 0;
  endtask

  initial begin
    int e0, h0;
    vecs[0] = '{4'h3, 16'd100, 0, 5'd0,  16'h0000, 5'd0,  16'h0000, 18'h2A530, 18'h1A530, 100};
    vecs[1] = '{4'h3, 16'd100, 2, 5'd5,  16'hFFFF, 5'd6,  16'h0002, 18'h2A530, 18'h1A531, 100};
    vecs[2] = '{4'h3, 16'd10,  0, 5'd0,  16'h0000, 5'd0,  16'h0000, 18'h2A530, 18'h1A530, 36};
    vecs[3] = '{4'hC, 16'd36,  1, 5'd31, 16'h0001, 5'd31, 16'h0001, 18'h2A5C0, 18'h1A5C1, 36};
    vecs[4] = '{4'hF, 16'd37,  2, 5'd0,  16'h5A40, 5'd1,  16'h0000, 18'h2A5F0, 18'h10030, 37};
    wa_nxt = 5'd0; wd_nxt = 16'h0; hook_a = 5'd0; hook_d = 16'h0;
    model_clear();

    // Table-driven frame scenarios.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      box_id = vecs[v].box;
      frame_period = vecs[v].period;
      if (vecs[v].nwr > 0) begin wr_nxt = 1; wa_nxt = vecs[v].a0; wd_nxt = vecs[v].d0; step(); end
      if (vecs[v].nwr > 1) begin wr_nxt = 1; wa_nxt = vecs[v].a1; wd_nxt = vecs[v].d1; step(); end
      wr_nxt = 0;
      tx_nxt = 1;
      for (int k = 0; k < 600 && obs_hdr_n < 2; k++) step();
      chk("vec_two_headers", 32'(obs_hdr_n >= 2), 32'd1);
      chk("vec_hdr", 32'(obs_hdr_w[0]), 32'(vecs[v].exp_hdr));
      chk("vec_csum", 32'(obs_eof_w[0]), 32'(vecs[v].exp_csum));
      chk("vec_gap", 32'(obs_hdr_cyc[1] - obs_hdr_cyc[0]), 32'(vecs[v].exp_gap));
      tx_nxt = 0;
      repeat (200) step();
    end

    // Write to word 0 during the header cycle: old value now, new value next frame.
    do_reset();
    box_id = 4'h3; frame_period = 16'd40;
    hook_wr = 1; hook_a = 5'd0; hook_d = 16'h1234;
    tx_nxt = 1;
    for (int k = 0; k < 300 && obs_eof_n < 2; k++) step();
    chk("snap_frames", 32'(obs_eof_n >= 2), 32'd1);
    chk("snap_w1_old", 32'(obs_w1[0]), 32'h00000);
    chk("snap_w1_new", 32'(obs_w1[1]), 32'h01234);

    // Drop tx_en at payload word 10: frame completes, nothing follows.
    hook_drop = 1;
    for (int k = 0; k < 300 && hook_drop; k++) step();
    chk("drop_hook_fired", 32'(hook_drop), 32'd0);
    e0 = obs_eof_n;
    for (int k = 0; k < 100 && obs_eof_n == e0; k++) step();
    chk("drop_eof", 32'(obs_eof_n), 32'(e0 + 1));
    h0 = obs_hdr_n;
    repeat (150) step();
    chk("drop_no_hdr", 32'(obs_hdr_n), 32'(h0));
    chk("drop_fcnt", 32'(frame_cnt), 32'(obs_eof_n));

    // Reset at payload word 20; next frame is fresh with cleared banks.
    do_reset();
    box_id = 4'h3; frame_period = 16'd50;
    wr_nxt = 1; wa_nxt = 5'd3; wd_nxt = 16'h1111; step();
    wr_nxt = 0; tx_nxt = 1;
    for (int k = 0; k < 200 && cur_pos != 20; k++) step();
    chk("rst_reach_w20", 32'(cur_pos), 32'd20);
    reset_now();
    tx_nxt = 1;
    for (int k = 0; k < 200 && obs_eof_n < 1; k++) step();
    chk("post_rst_frames", 32'(obs_eof_n), 32'd1);
    chk("post_rst_sof", 32'(obs_hdr_w[0]), 32'h2A530);
    chk("post_rst_csum", 32'(obs_eof_w[0]), 32'h1A530);
    tx_nxt = 0;
    repeat (100) step();

    // Randomized traffic against the model.
    do_reset();
    box_id = 4'($urandom);
    frame_period = 16'($urandom_range(10, 90));
    tx_nxt = 1;
    for (int k = 0; k < 3000; k++) begin
      wr_nxt = ($urandom_range(0, 3) == 0);
      wa_nxt = 5'($urandom);
      wd_nxt = 16'($urandom);
      if ($urandom_range(0, 149) == 0) tx_nxt = !tx_nxt;
      step();
    end
    wr_nxt = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
